// File: rtl/shared_net_arbiter.sv
// Round-robin owner arbiter and burst sequencer for one shared wide net.
// One requester owns the bus at a time. Its beats pass straight through to the bus.
// A burst ends on its last beat, or on a stall timeout. A one-cycle gap follows each burst.
module shared_net_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 30,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*LEN_W-1:0]     req_len,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  output logic [N_REQ-1:0]           grant,
  output logic [DATA_W-1:0]          bus_data,
  output logic                       bus_valid,
  input  logic                       bus_ready,
  output logic                       bus_last,
  output logic [$clog2(N_REQ)-1:0]   bus_owner,
  output logic                       timeout_err
);

  localparam int OW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  state_t            state_reg, state_next;
  logic [OW-1:0]     owner_reg, owner_next;
  logic [OW-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [LEN_W-1:0]  beats_left_reg, beats_left_next;
  logic [7:0]        stall_cnt_reg, stall_cnt_next;

  logic [LEN_W-1:0]  len_arr  [N_REQ];
  logic [DATA_W-1:0] data_arr [N_REQ];

  logic [OW:0]       scan_start;
  logic [2*N_REQ-1:0] rot_full;
  logic [N_REQ-1:0]  rot;
  logic [OW:0]       win_off;
  logic [OW:0]       win_sum;
  logic              win_found;
  logic [OW-1:0]     winner;

  logic              xfer;
  logic              own_valid;
  logic              beat;
  logic              timeout_hit;

  // Split the flattened per-requester fields into indexable arrays.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign len_arr[gi]  = req_len[gi*LEN_W +: LEN_W];
    assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // Rotate requests so that bit 0 is the requester just after rr_ptr, then take the first set bit.
  assign scan_start = {1'b0, rr_ptr_reg} + {{OW{1'b0}}, 1'b1};
  assign rot_full   = {req, req} >> scan_start;
  assign rot        = rot_full[N_REQ-1:0];

  // Priority scan over the rotated request vector.
  always_comb begin
    win_found = 1'b0;
    win_off   = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!win_found && rot[j]) begin
        win_found = 1'b1;
        win_off   = (OW+1)'(j);
      end
    end
  end

  // Undo the rotation. The sum is always below 2*N_REQ, so one conditional subtract wraps it.
  assign win_sum = scan_start + win_off;
  assign winner  = (win_sum >= (OW+1)'(N_REQ)) ? OW'(win_sum - (OW+1)'(N_REQ)) : OW'(win_sum);

  assign xfer        = (state_reg == XFER);
  assign own_valid   = req_valid[owner_reg];
  assign beat        = xfer && own_valid && bus_ready;
  assign timeout_hit = xfer && !beat && (stall_cnt_reg == 8'(TIMEOUT - 1));

  // Next-state logic for the arbitration/burst sequencer.
  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    rr_ptr_next     = rr_ptr_reg;
    beats_left_next = beats_left_reg;
    stall_cnt_next  = stall_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          owner_next      = winner;
          rr_ptr_next     = winner;
          beats_left_next = len_arr[winner];
          stall_cnt_next  = '0;
          state_next      = XFER;
        end
      end
      XFER: begin
        if (beat) begin
          stall_cnt_next = '0;
          if (beats_left_reg == '0) begin
            state_next = GAP;
          end else begin
            beats_left_next = beats_left_reg - 1'b1;
          end
        end else if (timeout_hit) begin
          state_next = GAP;
        end else if (stall_cnt_reg != 8'hFF) begin
          stall_cnt_next = stall_cnt_reg + 8'd1;
        end
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bus outputs: the owner's beat passes straight through while in XFER; otherwise the bus is quiet.
  always_comb begin
    grant       = '0;
    req_ready   = '0;
    bus_valid   = 1'b0;
    bus_data    = '0;
    bus_last    = 1'b0;
    bus_owner   = '0;
    timeout_err = 1'b0;
    if (xfer) begin
      grant[owner_reg]     = 1'b1;
      req_ready[owner_reg] = bus_ready;
      bus_owner            = owner_reg;
      bus_valid            = own_valid;
      bus_data             = own_valid ? data_arr[owner_reg] : '0;
      bus_last             = own_valid && (beats_left_reg == '0);
      timeout_err          = timeout_hit;
    end
  end

  // State registers. After reset rr_ptr points at the last requester, so requester 0 wins first.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      owner_reg      <= '0;
      rr_ptr_reg     <= OW'(N_REQ - 1);
      beats_left_reg <= '0;
      stall_cnt_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      rr_ptr_reg     <= rr_ptr_next;
      beats_left_reg <= beats_left_next;
      stall_cnt_reg  <= stall_cnt_next;
    end
  end

  a_grant_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(grant));
  a_ready_subset: assert property (@(posedge clock) disable iff (reset) (req_ready & ~grant) == '0);
  a_valid_owned:  assert property (@(posedge clock) disable iff (reset) bus_valid |-> (grant != '0));
  a_no_beat_to:   assert property (@(posedge clock) disable iff (reset) !(timeout_err && bus_valid && bus_ready));

endmodule

// File: tb/tb_shared_net_arbiter.sv
// Self-checking bench for shared_net_arbiter. It uses a directed vector table,
// hand-written corner sequences, and random traffic against a behavioural model.
module tb_shared_net_arbiter;

  localparam int N  = 4;
  localparam int DW = 30;
  localparam int LW = 4;
  localparam int TO = 15;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*LW-1:0] req_len;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    grant;
  logic [DW-1:0]   bus_data;
  logic            bus_valid;
  logic            bus_ready;
  logic            bus_last;
  logic [1:0]      bus_owner;
  logic            timeout_err;

  shared_net_arbiter #(.N_REQ(N), .DATA_W(DW), .LEN_W(LW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .req(req), .req_len(req_len), .req_data(req_data),
    .req_valid(req_valid), .req_ready(req_ready), .grant(grant), .bus_data(bus_data),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_last(bus_last),
    .bus_owner(bus_owner), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: the current owner (-1 when none), the beats still owed,
  // consecutive stalls, whether a gap cycle is pending, and the last winner.
  int m_owner = -1;
  int m_left  = 0;
  int m_stall = 0;
  bit m_gap   = 0;
  int m_last  = N - 1;

  // Values observed at the most recent sample point
  logic [N-1:0]  obs_grant, obs_ready;
  logic [DW-1:0] obs_data;
  logic          obs_valid, obs_last, obs_timeout;
  logic [1:0]    obs_owner;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_owner = -1; m_left = 0; m_stall = 0; m_gap = 0; m_last = N - 1;
  endtask

  // Advance the model by one clock, using the inputs that are present before the edge.
  task automatic m_advance();
    if (reset) begin
      m_reset();
    end else if (m_owner >= 0) begin
      if (req_valid[m_owner] && bus_ready) begin
        m_stall = 0;
        if (m_left == 0) begin m_owner = -1; m_gap = 1; end
        else m_left--;
      end else if (m_stall == TO - 1) begin
        m_owner = -1; m_gap = 1;
      end else begin
        m_stall++;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (req != '0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (req[c]) begin
          m_owner = c; m_left = int'(req_len[c*LW +: LW]); m_stall = 0; m_last = c;
          break;
        end
      end
    end
  endtask

  // One cycle: compare all outputs with the model at the falling edge, then advance the model.
  // The task returns just after the rising edge, so the caller can drive the next inputs.
  task automatic step();
    logic [N-1:0]  e_grant, e_ready;
    logic [DW-1:0] e_data;
    logic          e_valid, e_last, e_to;
    logic [1:0]    e_owner;
    @(negedge clock);
    e_grant = '0; e_ready = '0; e_data = '0; e_valid = 0; e_last = 0; e_to = 0; e_owner = '0;
    if (m_owner >= 0) begin
      e_grant = N'(1) << m_owner;
      e_valid = req_valid[m_owner];
      e_data  = e_valid ? req_data[m_owner*DW +: DW] : '0;
      e_ready = bus_ready ? e_grant : '0;
      e_last  = e_valid && (m_left == 0);
      e_owner = 2'(m_owner);
      e_to    = !(e_valid && bus_ready) && (m_stall == TO - 1);
    end
    chk("grant", grant, e_grant);
    chk("req_ready", req_ready, e_ready);
    chk("bus_valid", bus_valid, e_valid);
    chk("bus_data", bus_data, e_data);
    chk("bus_last", bus_last, e_last);
    chk("bus_owner", bus_owner, e_owner);
    chk("timeout_err", timeout_err, e_to);
    obs_grant = grant; obs_ready = req_ready; obs_data = bus_data; obs_valid = bus_valid;
    obs_last = bus_last; obs_owner = bus_owner; obs_timeout = timeout_err;
    m_advance();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; req_valid = '0; req_len = '0; req_data = '0; bus_ready = 1'b0;
    @(posedge clock);
    #1;
    m_reset();
    step();
    chk("reset_grant", obs_grant, '0);
    chk("reset_valid", obs_valid, 1'b0);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0]  req;
    logic [N-1:0]  valid;
    logic          rdy;
    logic [DW-1:0] d1;
    logic [N-1:0]  e_grant;
    logic [N-1:0]  e_ready;
    logic          e_valid;
    logic          e_last;
    logic [1:0]    e_owner;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t vecs[8];

  int gq[$];
  int idle_run;
  int beats;
  bit seen_grant;
  bit drop_grant;
  int vprob;

  initial begin
    // Directed vectors: requester 1 runs a 3-beat burst, then requester 3 runs a 1-beat burst.
    vecs[0] = '{4'b1010, 4'b1010, 1'b1, 30'h0A1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 30'h0};
    vecs[1] = '{4'b1010, 4'b1010, 1'b1, 30'h0A2, 4'b0010, 4'b0010, 1'b1, 1'b0, 2'd1, 30'h0A2};
    vecs[2] = '{4'b1010, 4'b1010, 1'b1, 30'h0A3, 4'b0010, 4'b0010, 1'b1, 1'b0, 2'd1, 30'h0A3};
    vecs[3] = '{4'b1010, 4'b1010, 1'b1, 30'h0A4, 4'b0010, 4'b0010, 1'b1, 1'b1, 2'd1, 30'h0A4};
    vecs[4] = '{4'b1010, 4'b1010, 1'b1, 30'h0A5, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 30'h0};
    vecs[5] = '{4'b1010, 4'b1010, 1'b1, 30'h0A6, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 30'h0};
    vecs[6] = '{4'b1010, 4'b1010, 1'b1, 30'h0A7, 4'b1000, 4'b1000, 1'b1, 1'b1, 2'd3, 30'h3333333};
    vecs[7] = '{4'b0000, 4'b1010, 1'b1, 30'h0A8, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 30'h0};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      req       = vecs[i].req;
      req_valid = vecs[i].valid;
      bus_ready = vecs[i].rdy;
      req_len   = {4'd0, 4'd0, 4'd2, 4'd0};
      req_data  = {30'h3333333, 30'h0, vecs[i].d1, 30'h0};
      step();
      chk("vec_grant", obs_grant, vecs[i].e_grant);
      chk("vec_ready", obs_ready, vecs[i].e_ready);
      chk("vec_valid", obs_valid, vecs[i].e_valid);
      chk("vec_last", obs_last, vecs[i].e_last);
      chk("vec_owner", obs_owner, vecs[i].e_owner);
      chk("vec_data", obs_data, vecs[i].e_data);
    end

    // All four request continuously with single-beat bursts: owners rotate 0,1,2,3,0 with two idle cycles between grants.
    do_reset();
    req = 4'b1111; req_len = '0; req_valid = 4'b1111; bus_ready = 1'b1;
    idle_run = 0; seen_grant = 0;
    for (int c = 0; c < 20; c++) begin
      req_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
      if (obs_grant != '0) begin
        for (int b = 0; b < N; b++) if (obs_grant[b]) gq.push_back(b);
        if (seen_grant) chk("rr_gap", idle_run, 2);
        seen_grant = 1; idle_run = 0;
      end else begin
        idle_run++;
      end
    end
    chk("rr_count", gq.size() >= 5, 1'b1);
    for (int i = 0; i < 5 && i < gq.size(); i++) chk("rr_order", gq[i], i % N);

    // Requester 2 runs 4 beats while bus_ready toggles. Each beat is counted exactly once.
    do_reset();
    req_len = {4'd0, 4'd3, 4'd0, 4'd0}; req_valid = 4'b0100; beats = 0;
    for (int c = 0; c < 14; c++) begin
      req = (c == 0) ? 4'b0100 : 4'b0000;
      bus_ready = (c % 2 == 0);
      req_data = {30'h0, 30'(c + 32'h100), 30'h0, 30'h0};
      step();
      if (obs_grant == 4'b0100) begin
        chk("t3_ready_mirror", obs_ready, bus_ready ? 4'b0100 : 4'b0000);
        if (obs_valid && bus_ready) begin
          beats++;
          chk("t3_data", obs_data, 30'(c + 32'h100));
          chk("t3_last", obs_last, beats == 4);
        end
      end
    end
    chk("t3_beats", beats, 4);

    // Requester 0 stalls with valid low. The timeout fires in the 15th stalled cycle, then requester 1 wins.
    do_reset();
    req = 4'b0011; req_len = '0; req_valid = '0; bus_ready = 1'b1; req_data = '1;
    step();
    for (int k = 1; k <= TO; k++) begin
      step();
      chk("t4_grant", obs_grant, 4'b0001);
      chk("t4_timeout", obs_timeout, k == TO);
    end
    step();
    chk("t4_gap", obs_grant, 4'b0000);
    step();
    chk("t4_idle", obs_grant, 4'b0000);
    step();
    chk("t4_next", obs_grant, 4'b0010);

    // Reset during beat 2 of a 5-beat burst: no timeout_err and no bus_last are emitted.
    do_reset();
    req = 4'b0001; req_len = {4'd0, 4'd0, 4'd0, 4'd4}; req_valid = 4'b0001; bus_ready = 1'b1;
    req_data = {30'h0, 30'h0, 30'h0, 30'h1234};
    step();
    step();
    chk("t5_beat1", obs_grant, 4'b0001);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("t5_grant", obs_grant, 4'b0000);
    chk("t5_valid", obs_valid, 1'b0);
    chk("t5_last", obs_last, 1'b0);
    chk("t5_to", obs_timeout, 1'b0);
    step();
    chk("t5_regrant", obs_grant, 4'b0001);

    // Requester 3 drops req after beat 1 of 3. The burst still completes, and requester 0 wins next.
    do_reset();
    req = 4'b1000; req_len = {4'd2, 4'd0, 4'd0, 4'd0}; req_valid = 4'b1000; bus_ready = 1'b1;
    req_data = {30'h77, 30'h0, 30'h0, 30'h11};
    step();
    step();
    chk("t6_beat1", obs_grant, 4'b1000);
    req = 4'b0000;
    step();
    chk("t6_beat2", obs_grant, 4'b1000);
    chk("t6_last2", obs_last, 1'b0);
    step();
    chk("t6_beat3", obs_grant, 4'b1000);
    chk("t6_last3", obs_last, 1'b1);
    req = 4'b1001;
    step();
    chk("t6_gap", obs_grant, 4'b0000);
    step();
    step();
    chk("t6_next", obs_grant, 4'b0001);

    // Random traffic checked cycle by cycle against the model.
    do_reset();
    vprob = 7;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) vprob = $urandom_range(0, 10);
      reset     = ($urandom_range(0, 299) == 0);
      req       = 4'($urandom());
      req_len   = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)),
                   4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
      for (int b = 0; b < N; b++) req_valid[b] = ($urandom_range(0, 9) < vprob);
      req_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shared_net_arbiter.md
Name: shared_net_arbiter

Overview:
- Round-robin arbiter and burst sequencer for one shared inter-module net.
- Several sibling instances drive the same wide bus. This block gives exactly one requester ownership at a time and sequences its burst of beats onto the bus.
- It enforces burst length and a stall timeout.
- Instantiated in mid/root-level wrappers wherever two or more children share a net.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_W, 30, shared bus width in bits.
- LEN_W, 4, burst-length field width. Burst beats = req_len + 1.
- TIMEOUT, 15, consecutive stalled cycles in XFER before abort (1..255).

Ports:
- clock  input  1  system clock, all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N_REQ  per-requester ownership request (level).
- req_len  input  N_REQ*LEN_W  per-requester burst length minus one. Slice i at [i*LEN_W +: LEN_W].
- req_data  input  N_REQ*DATA_W  per-requester beat data. Slice i at [i*DATA_W +: DATA_W].
- req_valid  input  N_REQ  per-requester beat valid.
- req_ready  output  N_REQ  beat accepted from requester (only the owner's bit can be 1).
- grant  output  N_REQ  one-hot current owner, 0 when bus free.
- bus_data  output  DATA_W  shared net data.
- bus_valid  output  1  beat present on shared net.
- bus_ready  input  1  sink accepts beat.
- bus_last  output  1  final beat of burst (qualified by bus_valid).
- bus_owner  output  clog2(N_REQ)  index of current owner, 0 when idle.
- timeout_err  output  1  one-cycle pulse on burst abort.

Behaviour:
- Reset values:
  - grant=0, req_ready=0, bus_valid=0, bus_last=0, bus_data=0, bus_owner=0, timeout_err=0.
  - state=IDLE, rr_ptr=N_REQ-1, so requester 0 wins first.
- States: IDLE, XFER, GAP.
- IDLE:
  - If any req bit set, winner = first set bit scanning from rr_ptr+1 upward, wrapping modulo N_REQ.
  - Latch owner=winner, beats_left=req_len[winner], stall_cnt=0, rr_ptr=winner. Go to XFER.
  - Arbitration latency: req high in cycle t gives grant in cycle t+1.
  - No request: stay in IDLE with all outputs at reset values.
- XFER:
  - grant[owner]=1 and bus_owner=owner.
  - bus_valid=req_valid[owner] and bus_data=req_data[owner], combinational pass-through.
  - req_ready[owner]=bus_ready; all other req_ready bits are 0.
  - When bus_valid=0, bus_data=0.
  - bus_last = bus_valid && beats_left==0.
  - Beat = bus_valid && bus_ready:
    - On a beat, beats_left decrements and stall_cnt clears.
    - On a beat with beats_left==0, go to GAP.
  - No beat in a cycle: stall_cnt increments (saturating).
  - stall_cnt reaching TIMEOUT-1 in a cycle with no beat:
    - timeout_err=1 in that same cycle.
    - Abort and go to GAP; remaining beats are dropped.
  - Owner deasserting req mid-burst is ignored; the burst runs to completion or timeout.
  - req_len changes after latching are ignored.
- GAP:
  - Exactly one cycle, bus idle: grant=0, all outputs at reset values. Then go to IDLE.
  - Minimum owner-to-owner turnaround is therefore 2 idle cycles (GAP plus IDLE arbitration).
- Fairness:
  - rr_ptr updates only on grant. With all requesters busy, ownership rotates 0,1,2,3,0...
- Reset mid-burst: the next cycle is IDLE with outputs at reset values. No timeout_err and no bus_last are emitted.
- Invariants (assert in sim):
  - grant is one-hot or zero.
  - req_ready is a subset of grant.
  - bus_valid implies grant != 0.
  - timeout_err and a beat never occur in the same cycle.

Test Plan:
1. After reset, req=4'b1010 with req_len[1]=2 and req_valid[1]=1, bus_ready=1:
   - grant=4'b0010 one cycle after req.
   - Three beats with data passed through; bus_last on the 3rd beat.
   - GAP, then IDLE, then grant=4'b1000.
2. req=4'b1111 held, every req_len=0, valid and ready always 1:
   - grants in order 0,1,2,3,0, each single-beat.
   - Two idle cycles between consecutive grants.
3. Owner 2 with req_len=3 and bus_ready toggling 1,0,1,0:
   - Exactly 4 beats, with req_ready[2] mirroring bus_ready.
   - No beat lost or duplicated; bus_last only on beat 4.
4. Owner 0 with req_valid[0]=0 for TIMEOUT=15 cycles:
   - timeout_err pulses in the 15th stalled cycle, then GAP.
   - Next grant goes to requester 1 if it is requesting.
5. Reset asserted during beat 2 of a 5-beat burst:
   - Next cycle all outputs at reset values.
   - Subsequent req=4'b0001 is granted to requester 0.
6. Owner 3 drops req after beat 1 of 3:
   - Burst completes all 3 beats.
   - rr_ptr=3, so next arbitration with req=4'b1001 grants requester 0.
